// File: rtl/hdlverifier_jtag_shift_in_deser.sv
// -----------------------------------------------------------------------------
// hdlverifier_jtag_shift_in_deser
//
// Purpose:
//   Consumes the JTAG core's bulk-write interface. The serial stream arrives
//   LSB first and is packed into DATA_WIDTH-bit words. The words are buffered
//   in a first-word-fall-through FIFO and leave on a valid/ready stream. A
//   last-word marker identifies the final word of each burst. All logic runs
//   on the rising edge of tck.
//
// Optional feature (macro SHIFT_IN_PAD_EN):
//   When the macro is defined, a trailing partial word is zero-extended and
//   emitted as the last word of its burst. When it is undefined, the partial
//   bits are discarded and no padding logic is built.
//
// Ports:
//   tck            JTAG clock
//   reset          asynchronous, active-high; clears all state
//   shift_in_state high for the whole bulk-write burst
//   shift_in_en    qualifies shift_in_data for one tck
//   shift_in_data  serial data bit, LSB of each word first
//   clr_status     one-cycle pulse; clears the sticky flags
//   m_tdata        FIFO head word (0 when empty)
//   m_tlast        FIFO head is the last word of its burst
//   m_tvalid       FIFO not empty
//   m_tready       consumer accepts the head word
//   fifo_level     number of FIFO entries, 0..FIFO_DEPTH
//   overflow       sticky: a word was dropped because the FIFO was full
//   partial_err    sticky: a burst ended with a partial word
//   proto_err      sticky: shift_in_en was seen outside SHIFT
// -----------------------------------------------------------------------------
module hdlverifier_jtag_shift_in_deser #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  tck,
  input  logic                  reset,
  input  logic                  shift_in_state,
  input  logic                  shift_in_en,
  input  logic                  shift_in_data,
  input  logic                  clr_status,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [ADDR_WIDTH:0]   fifo_level,
  output logic                  overflow,
  output logic                  partial_err,
  output logic                  proto_err
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
`ifdef SHIFT_IN_PAD_EN
    FLUSH2,
`endif
    FLUSH
  } state_t;

  state_t                state_reg;
  logic [DATA_WIDTH-1:0] shreg_reg;
  logic [CW-1:0]         bit_cnt_reg;
  logic [DATA_WIDTH-1:0] stg_data_reg;
  logic                  stg_valid_reg;
  logic                  push_reg;
  logic [DATA_WIDTH-1:0] push_data_reg;
  logic                  push_last_reg;
  logic [DATA_WIDTH-1:0] next_word;

  // The word as it stands once the current bit has been shifted in.
  assign next_word = {shift_in_data, shreg_reg[DATA_WIDTH-1:1]};

`ifdef SHIFT_IN_PAD_EN
  // Received bits sit in the top bit_cnt positions of shreg; right-align them.
  logic [CW:0]           pad_shift;
  logic [DATA_WIDTH-1:0] padded;
  always_comb begin
    pad_shift = (CW+1)'(DATA_WIDTH) - {1'b0, bit_cnt_reg};
    padded    = shreg_reg >> pad_shift;
  end
`endif

  // Burst FSM. Pushes toward the FIFO are registered (push_reg) so the FIFO
  // sees at most one word per cycle and the FSM outputs stay registered.
  always_ff @(posedge tck or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      shreg_reg     <= '0;
      bit_cnt_reg   <= '0;
      stg_data_reg  <= '0;
      stg_valid_reg <= 1'b0;
      push_reg      <= 1'b0;
      push_data_reg <= '0;
      push_last_reg <= 1'b0;
      partial_err   <= 1'b0;
      proto_err     <= 1'b0;
    end else begin
      push_reg <= 1'b0;
      // Clear first so that a set later in this block takes priority.
      if (clr_status) begin
        partial_err <= 1'b0;
        proto_err   <= 1'b0;
      end
      if (shift_in_en && state_reg != SHIFT) proto_err <= 1'b1;

      case (state_reg)
        IDLE: begin
          if (shift_in_state) begin
            state_reg     <= SHIFT;
            bit_cnt_reg   <= '0;
            stg_valid_reg <= 1'b0;
          end
        end

        SHIFT: begin
          if (shift_in_en) begin
            shreg_reg <= next_word;
            if (bit_cnt_reg == CW'(DATA_WIDTH - 1)) begin
              bit_cnt_reg   <= '0;
              stg_data_reg  <= next_word;
              stg_valid_reg <= 1'b1;
              // The previous word is now known not to be the last one.
              if (stg_valid_reg) begin
                push_reg      <= 1'b1;
                push_data_reg <= stg_data_reg;
                push_last_reg <= 1'b0;
              end
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
          end
          if (!shift_in_state) state_reg <= FLUSH;
        end

        FLUSH: begin
          if (bit_cnt_reg != '0) partial_err <= 1'b1;
          stg_valid_reg <= 1'b0;
`ifdef SHIFT_IN_PAD_EN
          if (bit_cnt_reg != '0) begin
            push_reg <= 1'b1;
            if (stg_valid_reg) begin
              // Staged word goes first; the padded word follows next cycle.
              push_data_reg <= stg_data_reg;
              push_last_reg <= 1'b0;
              state_reg     <= FLUSH2;
            end else begin
              push_data_reg <= padded;
              push_last_reg <= 1'b1;
              bit_cnt_reg   <= '0;
              state_reg     <= IDLE;
            end
          end else begin
            if (stg_valid_reg) begin
              push_reg      <= 1'b1;
              push_data_reg <= stg_data_reg;
              push_last_reg <= 1'b1;
            end
            state_reg <= IDLE;
          end
`else
          if (stg_valid_reg) begin
            push_reg      <= 1'b1;
            push_data_reg <= stg_data_reg;
            push_last_reg <= 1'b1;
          end
          bit_cnt_reg <= '0;
          state_reg   <= IDLE;
`endif
        end

`ifdef SHIFT_IN_PAD_EN
        FLUSH2: begin
          push_reg      <= 1'b1;
          push_data_reg <= padded;
          push_last_reg <= 1'b1;
          bit_cnt_reg   <= '0;
          state_reg     <= IDLE;
        end
`endif

        default: state_reg <= IDLE;
      endcase
    end
  end

  // First-word-fall-through FIFO. Each entry is {tlast, data}.
  logic [DATA_WIDTH:0] mem [FIFO_DEPTH];
  logic [ADDR_WIDTH:0] wr_ptr_reg;
  logic [ADDR_WIDTH:0] rd_ptr_reg;
  logic [DATA_WIDTH:0] head;
  logic                full;
  logic                pop;
  logic                wr_en;

  assign full     = (fifo_level == (ADDR_WIDTH+1)'(FIFO_DEPTH));
  assign m_tvalid = (fifo_level != '0);
  assign pop      = m_tvalid & m_tready;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign wr_en    = push_reg & (~full | pop);
  assign head     = mem[rd_ptr_reg[ADDR_WIDTH-1:0]];

  always_comb begin
    m_tdata = m_tvalid ? head[DATA_WIDTH-1:0] : '0;
    m_tlast = m_tvalid & head[DATA_WIDTH];
  end

  always_ff @(posedge tck) begin
    if (wr_en) mem[wr_ptr_reg[ADDR_WIDTH-1:0]] <= {push_last_reg, push_data_reg};
  end

  always_ff @(posedge tck or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({wr_en, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      if (clr_status) overflow <= 1'b0;
      if (push_reg && full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: doc/hdlverifier_jtag_shift_in_deser.md
Name: hdlverifier_jtag_shift_in_deser

Overview:
Downstream consumer of the JTAG core's bulk-write interface (shift_in_state / shift_in_en / shift_in_data). Packs the LSB-first serial bit stream into DATA_WIDTH-bit words. Buffers the words in a first-word-fall-through FIFO and presents them on a valid/ready stream with a last-word marker per burst. Runs entirely in the tck domain; user logic or a CDC FIFO consumes the stream.

Parameters:
DATA_WIDTH, 32, bits per output word; must be ≥ 2.
FIFO_DEPTH, 16, FIFO entries; must be a power of 2.
ADDR_WIDTH, 4, log2(FIFO_DEPTH).

Ports:
tck  input  1  JTAG clock; all logic on rising edge.
reset  input  1  asynchronous, active-high; clears all state.
shift_in_state  input  1  high for the whole bulk-write burst.
shift_in_en  input  1  qualifies shift_in_data for one tck.
shift_in_data  input  1  serial data bit, LSB of each word first.
clr_status  input  1  one-cycle pulse; clears the sticky flags.
m_tdata  output  DATA_WIDTH  FIFO head word.
m_tlast  output  1  FIFO head is the last word of its burst.
m_tvalid  output  1  FIFO not empty.
m_tready  input  1  consumer accepts the head word.
fifo_level  output  ADDR_WIDTH+1  current number of FIFO entries, 0..FIFO_DEPTH.
overflow  output  1  sticky: a word was dropped because the FIFO was full.
partial_err  output  1  sticky: a burst ended with a non-multiple-of-DATA_WIDTH bit count.
proto_err  output  1  sticky: shift_in_en was seen while not in SHIFT.

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE, bit counter 0, staging register invalid.
- FSM states:
  - IDLE: on shift_in_state=1, go to SHIFT, clear bit_cnt, invalidate staging.
  - SHIFT: each shift_in_en does shreg <= {shift_in_data, shreg[DATA_WIDTH-1:1]} and bit_cnt++.
    - On the bit where bit_cnt == DATA_WIDTH-1, the word is complete and bit_cnt wraps to 0.
    - If staging is valid, push staging with tlast=0. Staging always takes the new word (valid=1).
    - On shift_in_state=0 (sampled high→low; en in the same cycle is still shifted), go to FLUSH.
  - FLUSH (1 or 2 cycles):
    - Push staging with tlast=1 if it is valid and no partial word is being emitted.
    - If bit_cnt != 0, set partial_err; partial bits are discarded (see Optional Feature).
    - Then go to IDLE.
  - IDLE→SHIFT is re-evaluated on the cycle after FLUSH ends, so back-to-back bursts are supported.
- shift_in_en in IDLE or FLUSH: bit ignored, proto_err set.
- Latency: the last word of a burst appears at m_tvalid 2 tck after shift_in_state falls. Any other word appears 1 tck after the following word completes.
- A burst of N complete words yields exactly N FIFO entries; only the final one has tlast=1.
- A burst with 0 complete words pushes nothing.
- FIFO: push at most one word per cycle. Pop when m_tvalid & m_tready.
  - Push while full without a same-cycle pop: word dropped, overflow set, level unchanged.
  - Push while full with a same-cycle pop: accepted, level unchanged.
  - Push and pop together when empty: not possible, because of first-word-fall-through.
- fifo_level is registered and exact every cycle.
- Pointers are ADDR_WIDTH+1 bits and wrap modulo 2·FIFO_DEPTH.
- Sticky flags: set has priority over clr_status in the same cycle.
- Reset mid-burst: everything is cleared immediately, including FIFO contents.

Optional Feature:
Macro SHIFT_IN_PAD_EN.
- Defined: at FLUSH with bit_cnt != 0, the partial word is zero-extended in its upper bits (received bits right-aligned at LSB) and pushed with tlast=1.
  - If staging is also valid, staging is pushed first with tlast=0 (FLUSH cycle 1), then the padded word (FLUSH cycle 2).
  - partial_err is still set.
- Undefined: partial bits are discarded, FLUSH is 1 cycle, and no padding logic is built.

Test Plan:
- 64 en bits with data 0xDEADBEEF then 0x12345678 (LSB first), m_tready=1 → two beats 0xDEADBEEF (tlast=0), 0x12345678 (tlast=1); no flags set.
- m_tready=0, burst of 17 words → fifo_level=16, overflow=1, the 17th word lost. Then m_tready=1 → 16 words drain in order, last beat tlast=0; clr_status clears overflow.
- Burst of 40 bits = 0xAAAAAAAA + 8 bits 0x5A:
  - Without macro: one beat 0xAAAAAAAA with tlast=1; partial_err=1.
  - With SHIFT_IN_PAD_EN: 0xAAAAAAAA (tlast=0), then 0x0000005A (tlast=1); partial_err=1.
- Two back-to-back 1-word bursts with shift_in_state low for 3 tck between them → two beats, both tlast=1.
- Assert reset after 20 bits of a burst, then run a clean 32-bit burst 0x00000001 → only that word is output; fifo_level goes 0→1.
- shift_in_en pulsed while shift_in_state=0 → proto_err=1, no FIFO push.
